lhs_shift_sequencer: RTL
========================

Name: lhs_shift_sequencer

Overview:
Multi-step controller for the single-step left-hand-side shifter stage (zero / shift-right / shift-left / pass-through, 1 bit per ALU strobe). Accepts one shift request (direction, count, fill mode, value, carry), issues count single-bit operations to the shifter, and feeds each result back as the next input. It generates the shifter's step strobe and computes the per-step carry-in for fill, rotate and rotate-through-carry modes. It returns the final value and carry over a valid/ready response channel. It sits between the instruction decode/microcode and the shifter stage.

Parameters:
WIDTH, 8, datapath width; must equal the shifter stage width (>=2)
CNT_W, 4, width of shift count; counts 0..2^CNT_W-1

Ports:
clk  in  1  system clock; all state changes on posedge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE; request accepted on clk edge with req_valid&req_ready
req_dir  in  1  0=left, 1=right
req_fill  in  2  00 fill 0, 01 fill 1, 10 rotate through carry, 11 rotate
req_clear  in  1  1=zero operation; overrides dir/fill/count
req_count  in  CNT_W  number of single-bit steps
req_value  in  WIDTH  operand
req_carry  in  1  initial carry
resp_valid  out  1  result available; held until resp_ready
resp_ready  in  1  consumer accepts result
resp_value  out  WIDTH  final value
resp_carry  out  1  final carry
busy  out  1  high in any state except IDLE
lhs_operation  out  2  to shifter: 11 zero, 10 right, 01 left, 00 pass
lhs_in  out  WIDTH  to shifter data input
lhs_carry_in  out  1  to shifter carry input
lhs_step  out  1  one-clk strobe; top level derives the shifter's ALU clock edge from it
lhs_out  in  WIDTH  shifter registered result
lhs_carry_out  in  1  shifter registered carry

Behaviour:
- States: IDLE, ISSUE, CAPTURE, DONE; all registered.
- Reset: state=IDLE, req_ready=1, busy=0, resp_valid=0, resp_value=0, resp_carry=0, lhs_step=0, lhs_operation=00, lhs_in=0, lhs_carry_in=0. Remaining-count and working value/carry registers are cleared.
- IDLE: on accept, latch the request. Working value=req_value, working carry=req_carry, remaining=max(req_count,1). Go to ISSUE.
- Operation per step:
  - req_clear: 11, single step.
  - count 0: 00 (pass), single step.
  - Otherwise: 01 if dir=0, 10 if dir=1.
- ISSUE: lhs_step=1 for exactly this cycle. lhs_in=working value. lhs_operation per the rule above. Go to CAPTURE.
- lhs_carry_in in ISSUE:
  - fill 00 -> 0.
  - fill 01 -> 1.
  - fill 10 -> working carry.
  - fill 11 -> working value MSB when dir=0, LSB when dir=1.
  - Pass and zero steps drive the working carry.
- CAPTURE: lhs_step=0. Sample lhs_out/lhs_carry_out into working value/carry and decrement remaining.
  - remaining was 1 -> DONE, with resp_value/resp_carry loaded from lhs_out/lhs_carry_out.
  - Else -> ISSUE.
- Result carry is the last shifted-out bit in all shift modes. Zero gives carry 0. Pass gives req_carry.
- Latency: resp_valid rises 2*max(N,1) clk edges after the accept edge (N=count; 1 for clear).
- DONE: resp_valid=1, outputs stable. When resp_ready=1 on an edge -> IDLE (req_ready=1 the next cycle). No new request is accepted in the same cycle.
- resp_ready low holds DONE indefinitely; values are unchanged.
- lhs_operation/lhs_in hold their ISSUE values through CAPTURE. They return to 00/0 in IDLE and DONE.
- rst mid-operation: IDLE on the next edge. Any in-flight result is discarded, resp_valid=0, lhs_step=0. No further strobe is issued.
- The shifter has no reset. The sequencer never uses lhs_out except in a CAPTURE that follows its own strobe.
- Requests with req_valid low, or arriving while busy, are ignored (req_ready=0).
- Counts greater than WIDTH are legal and execute every step. No truncation.

Test Plan:
- Left shift, fill 0, count 3, value 0x81, carry 0 -> resp 0x08, carry 0. resp_valid 6 edges after accept. Exactly 3 lhs_step pulses.
- Right shift, fill 1, count 2, value 0x00 -> 0xC0, carry 0. Then rotate-through-carry right, count 1, value 0x01, carry 0 -> 0x00, carry 1.
- Rotate left, count 8, value 0xA5 -> 0xA5, carry 1. Rotate right, count 4, value 0x12 -> 0x21, carry 0.
- Count 0, value 0x5A, carry 1 -> 0x5A, carry 1, latency 2, operation 00. req_clear with 0xFF, count 5 -> 0x00, carry 0, one step, operation 11.
- Backpressure: hold resp_ready=0 for 10 cycles. resp_valid and value stay stable, req_ready=0, a competing req_valid is ignored. Raise resp_ready -> IDLE next cycle.
- Assert rst during the CAPTURE of step 2 of a count-5 shift. Next cycle: IDLE, resp_valid=0, lhs_step=0, req_ready=1. A follow-up request completes correctly.

Source files
------------

// File: rtl/lhs_shift_sequencer.sv
// lhs_shift_sequencer
// Sequences a multi-bit shift on a single-step shifter stage. A request is
// split into single-bit operations. Each result is fed back as the next input,
// and the final value and carry are returned over a valid/ready channel.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   req_valid / req_ready        request handshake (ready only in IDLE)
//   req_dir, req_fill, req_clear request controls (direction, fill mode, zero)
//   req_count, req_value, req_carry  step count, operand, initial carry
//   resp_valid / resp_ready      response handshake (valid held until ready)
//   resp_value, resp_carry       final value and carry
//   busy                         high whenever not IDLE
//   lhs_operation, lhs_in,
//   lhs_carry_in, lhs_step       drive to the shifter stage (step = strobe)
//   lhs_out, lhs_carry_out       registered result from the shifter stage
module lhs_shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_dir,
  input  logic [1:0]       req_fill,
  input  logic             req_clear,
  input  logic [CNT_W-1:0] req_count,
  input  logic [WIDTH-1:0] req_value,
  input  logic             req_carry,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_value,
  output logic             resp_carry,
  output logic             busy,
  output logic [1:0]       lhs_operation,
  output logic [WIDTH-1:0] lhs_in,
  output logic             lhs_carry_in,
  output logic             lhs_step,
  input  logic [WIDTH-1:0] lhs_out,
  input  logic             lhs_carry_out
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [1:0] OP_PASS  = 2'b00;
  localparam logic [1:0] OP_LEFT  = 2'b01;
  localparam logic [1:0] OP_RIGHT = 2'b10;
  localparam logic [1:0] OP_ZERO  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       fill_q, fill_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             req_ready_q, req_ready_d;
  logic             busy_q, busy_d;
  logic             resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] resp_value_q, resp_value_d;
  logic             resp_carry_q, resp_carry_d;
  logic [1:0]       lhs_op_q, lhs_op_d;
  logic [WIDTH-1:0] lhs_in_q, lhs_in_d;
  logic             lhs_cin_q, lhs_cin_d;
  logic             lhs_step_q, lhs_step_d;

  logic [1:0]       req_op_s;
  logic [CNT_W-1:0] req_rem_s;

  // Carry fed into the shifter for one step. Pass and zero steps simply
  // forward the working carry; rotate uses the bit about to fall off.
  function automatic logic step_carry_in(input logic [1:0]       op,
                                         input logic [1:0]       fill,
                                         input logic             dir,
                                         input logic [WIDTH-1:0] val,
                                         input logic             carry);
    logic cin;
    case (op)
      OP_LEFT, OP_RIGHT: begin
        case (fill)
          2'b00:   cin = 1'b0;
          2'b01:   cin = 1'b1;
          2'b10:   cin = carry;
          2'b11:   cin = dir ? val[0] : val[WIDTH-1];
          default: cin = 1'b0;
        endcase
      end
      default: cin = carry;
    endcase
    return cin;
  endfunction

  // Zero and pass requests collapse to one step; a count of 0 means pass.
  assign req_op_s  = req_clear ? OP_ZERO :
                     (req_count == '0) ? OP_PASS :
                     (req_dir ? OP_RIGHT : OP_LEFT);
  assign req_rem_s = (req_clear || (req_count == '0)) ? CNT_ONE : req_count;

  // Next-state logic; every output is registered from these next values so
  // the strobe and shifter controls line up with the state they belong to.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    fill_d       = fill_q;
    dir_d        = dir_q;
    val_d        = val_q;
    carry_d      = carry_q;
    rem_d        = rem_q;
    req_ready_d  = req_ready_q;
    busy_d       = busy_q;
    resp_valid_d = resp_valid_q;
    resp_value_d = resp_value_q;
    resp_carry_d = resp_carry_q;
    lhs_op_d     = lhs_op_q;
    lhs_in_d     = lhs_in_q;
    lhs_cin_d    = lhs_cin_q;
    lhs_step_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d     = ST_ISSUE;
          op_d        = req_op_s;
          fill_d      = req_fill;
          dir_d       = req_dir;
          val_d       = req_value;
          carry_d     = req_carry;
          rem_d       = req_rem_s;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          lhs_step_d  = 1'b1;
          lhs_op_d    = req_op_s;
          lhs_in_d    = req_value;
          lhs_cin_d   = step_carry_in(req_op_s, req_fill, req_dir, req_value, req_carry);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        val_d   = lhs_out;
        carry_d = lhs_carry_out;
        rem_d   = rem_q - CNT_ONE;
        if (rem_q == CNT_ONE) begin
          state_d      = ST_DONE;
          resp_valid_d = 1'b1;
          resp_value_d = lhs_out;
          resp_carry_d = lhs_carry_out;
          lhs_op_d     = OP_PASS;
          lhs_in_d     = '0;
          lhs_cin_d    = 1'b0;
        end else begin
          state_d    = ST_ISSUE;
          lhs_step_d = 1'b1;
          lhs_in_d   = lhs_out;
          lhs_cin_d  = step_carry_in(op_q, fill_q, dir_q, lhs_out, lhs_carry_out);
        end
      end
      ST_DONE: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          busy_d       = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        req_ready_d  = 1'b1;
        busy_d       = 1'b0;
        resp_valid_d = 1'b0;
        lhs_op_d     = OP_PASS;
        lhs_in_d     = '0;
        lhs_cin_d    = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_PASS;
      fill_q       <= 2'b00;
      dir_q        <= 1'b0;
      val_q        <= '0;
      carry_q      <= 1'b0;
      rem_q        <= '0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_value_q <= '0;
      resp_carry_q <= 1'b0;
      lhs_op_q     <= OP_PASS;
      lhs_in_q     <= '0;
      lhs_cin_q    <= 1'b0;
      lhs_step_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      fill_q       <= fill_d;
      dir_q        <= dir_d;
      val_q        <= val_d;
      carry_q      <= carry_d;
      rem_q        <= rem_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      resp_value_q <= resp_value_d;
      resp_carry_q <= resp_carry_d;
      lhs_op_q     <= lhs_op_d;
      lhs_in_q     <= lhs_in_d;
      lhs_cin_q    <= lhs_cin_d;
      lhs_step_q   <= lhs_step_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign busy          = busy_q;
  assign resp_valid    = resp_valid_q;
  assign resp_value    = resp_value_q;
  assign resp_carry    = resp_carry_q;
  assign lhs_operation = lhs_op_q;
  assign lhs_in        = lhs_in_q;
  assign lhs_carry_in  = lhs_cin_q;
  assign lhs_step      = lhs_step_q;

endmodule
